// File: rtl/bpb_commit_queue.sv
// Commit-side queue feeding the branch predictor buffer: accepts up to two resolved
// branches per cycle, raises a registered redirect on mispredict, drains one update per cycle.
module bpb_commit_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       in_valid,
    input  logic [1:0][31:0] in_pc,
    input  logic [1:0]       in_taken,
    input  logic [1:0][31:0] in_destpc,
    input  logic [1:0]       in_pred_taken,
    input  logic [1:0][31:0] in_pred_destpc,
    output logic             in_ready,
    output logic [31:0]      pc_commit,
    output logic             wen,
    output logic [32:0]      destpc_commit,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [64:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, tail1;
    logic [PTR_W:0]   count_q, count_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

    logic [1:0] mis;
    logic       acc0, acc1, deq, fire0, fire1, sel;
    logic [1:0] n_acc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign in_ready      = (count_q <= (PTR_W+1)'(DEPTH-2));
    assign wen           = (count_q != '0);
    assign pc_commit     = mem_q[head_q][64:33];
    assign destpc_commit = mem_q[head_q][32:0];
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mis[i] = (in_taken[i] != in_pred_taken[i]) ||
                     (in_taken[i] && (in_destpc[i] != in_pred_destpc[i]));
        end
        acc0  = in_valid[0] & in_ready;
        // a mispredicting lane 0 makes lane 1 wrong-path
        acc1  = in_valid[1] & in_ready & ~(acc0 & mis[0]);
        fire0 = acc0 & mis[0];
        fire1 = acc1 & mis[1];
        sel   = ~fire0;
        n_acc = {1'b0, acc0} + {1'b0, acc1};
        deq   = wen & ~stall;

        tail1   = tail_q + PTR_W'(acc0);
        tail_d  = tail_q + PTR_W'(n_acc);
        head_d  = head_q + PTR_W'(deq);
        count_d = count_q + (PTR_W+1)'(n_acc) - (PTR_W+1)'(deq);

        mispredict_d  = fire0 | fire1;
        redirect_pc_d = redirect_pc_q;
        if (fire0 | fire1) begin
            redirect_pc_d = in_taken[sel] ? in_destpc[sel] : in_pc[sel] + 32'd8;
        end

        branch_cnt_d  = sat_add(branch_cnt_q, n_acc);
        mispred_cnt_d = sat_add(mispred_cnt_q, {1'b0, fire0 | fire1});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (acc0) mem_q[tail_q] <= {in_pc[0], in_taken[0], in_destpc[0]};
        if (acc1) mem_q[tail1]  <= {in_pc[1], in_taken[1], in_destpc[1]};
    end

    assert property (@(posedge clk) disable iff (reset) !((|in_valid) && !in_ready));

endmodule

// File: tb/tb_bpb_commit_queue.sv
// Scoreboard bench for bpb_commit_queue: directed scenarios followed by random traffic,
// compared against a queue-based reference model.
module tb_bpb_commit_queue;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stall = 1'b0;
    logic [1:0]       in_valid = '0;
    logic [1:0][31:0] in_pc = '0;
    logic [1:0]       in_taken = '0;
    logic [1:0][31:0] in_destpc = '0;
    logic [1:0]       in_pred_taken = '0;
    logic [1:0][31:0] in_pred_destpc = '0;
    logic             in_ready, wen, mispredict;
    logic [31:0]      pc_commit, redirect_pc;
    logic [32:0]      destpc_commit;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    bpb_commit_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_pc(in_pc),
        .in_taken(in_taken), .in_destpc(in_destpc), .in_pred_taken(in_pred_taken),
        .in_pred_destpc(in_pred_destpc), .in_ready(in_ready), .pc_commit(pc_commit),
        .wen(wen), .destpc_commit(destpc_commit), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    logic [64:0]      exp_q[$];
    logic             exp_mis = 1'b0;
    logic [31:0]      exp_rpc = '0;
    logic [CNT_W-1:0] exp_bcnt = '0, exp_mcnt = '0;
    bit               mon_en = 1'b0;
    int               checks = 0, failures = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input int n);
        return (a > {CNT_W{1'b1}} - CNT_W'(n)) ? {CNT_W{1'b1}} : a + CNT_W'(n);
    endfunction

    // Drives one cycle starting just after a rising edge; model updates at the closing edge.
    task automatic step(input logic [1:0] v, input logic [1:0][31:0] pc, input logic [1:0] tk,
                        input logic [1:0][31:0] dp, input logic [1:0] ptk,
                        input logic [1:0][31:0] pdp, input logic st);
        logic a0, a1, m0, m1;
        int   s;
        if (exp_q.size() > DEPTH-2) v = 2'b00;
        in_valid = v; in_pc = pc; in_taken = tk; in_destpc = dp;
        in_pred_taken = ptk; in_pred_destpc = pdp; stall = st;
        m0 = (tk[0] != ptk[0]) || (tk[0] && dp[0] != pdp[0]);
        m1 = (tk[1] != ptk[1]) || (tk[1] && dp[1] != pdp[1]);
        a0 = v[0];
        a1 = v[1] && !(a0 && m0);
        @(posedge clk);
        if (a0) exp_q.push_back({pc[0], tk[0], dp[0]});
        if (a1) exp_q.push_back({pc[1], tk[1], dp[1]});
        exp_bcnt = sat(exp_bcnt, int'(a0) + int'(a1));
        exp_mis = (a0 && m0) || (a1 && m1);
        if (exp_mis) begin
            s = (a0 && m0) ? 0 : 1;
            exp_rpc = tk[s] ? dp[s] : pc[s] + 32'd8;
            exp_mcnt = sat(exp_mcnt, 1);
        end
        #1;
    endtask

    task automatic idle(input logic st);
        step(2'b00, '0, '0, '0, '0, '0, st);
    endtask

    task automatic one(input logic [31:0] pc, input logic st);
        step(2'b01, {32'h0, pc}, 2'b01, {32'h0, pc + 32'h40}, 2'b01, {32'h0, pc + 32'h40}, st);
    endtask

    // Monitor: mid-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                check("wen", {64'h0, wen}, {64'h0, exp_q.size() != 0});
                check("in_ready", {64'h0, in_ready}, {64'h0, exp_q.size() <= DEPTH-2});
                if (exp_q.size() != 0) begin
                    check("head", {pc_commit, destpc_commit}, exp_q[0]);
                    if (!stall) void'(exp_q.pop_front());
                end
                check("mispredict", {64'h0, mispredict}, {64'h0, exp_mis});
                check("redirect_pc", {33'h0, redirect_pc}, {33'h0, exp_rpc});
                check("branch_cnt", {33'h0, branch_cnt}, {33'h0, exp_bcnt});
                check("mispred_cnt", {33'h0, mispred_cnt}, {33'h0, exp_mcnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]       v, tk, ptk;
        logic [1:0][31:0] pc, dp, pdp;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_wen", {64'h0, wen}, 65'h0);
        check("reset_ready", {64'h0, in_ready}, 65'h1);
        check("reset_bcnt", {33'h0, branch_cnt}, 65'h0);
        mon_en = 1'b1;

        // single correct prediction
        step(2'b01, {32'h0, 32'h80000100}, 2'b01, {32'h0, 32'h80000200},
             2'b01, {32'h0, 32'h80000200}, 1'b0);
        repeat (2) idle(1'b0);
        // dual lane, no mispredict
        step(2'b11, {32'h180, 32'h100}, 2'b11, {32'h280, 32'h200},
             2'b11, {32'h280, 32'h200}, 1'b0);
        repeat (3) idle(1'b0);
        // lane 0 direction mispredict: lane 1 dropped, redirect to pc+8
        step(2'b11, {32'h480, 32'h400}, 2'b10, {32'h580, 32'h500},
             2'b11, {32'h580, 32'h500}, 1'b0);
        idle(1'b0);
        check("redir_dir", {33'h0, redirect_pc}, {33'h0, 32'h408});
        repeat (2) idle(1'b0);
        // lane 0 target mispredict
        step(2'b01, {32'h0, 32'h600}, 2'b01, {32'h0, 32'h900},
             2'b01, {32'h0, 32'h800}, 1'b0);
        idle(1'b0);
        check("redir_tgt", {33'h0, redirect_pc}, {33'h0, 32'h900});
        // lane 1 mispredict only
        step(2'b11, {32'hA80, 32'hA00}, 2'b00, {32'hB80, 32'hB00},
             2'b10, {32'hB80, 32'hB00}, 1'b0);
        repeat (3) idle(1'b0);

        // fill under stall: 1,3,5,7 entries, then drain across the wrap
        one(32'hC00, 1'b1);
        for (int i = 0; i < 4; i++)
            step(2'b11, {32'hD00 + 32'(i*16) + 32'h8, 32'hD00 + 32'(i*16)}, 2'b00, '0, 2'b00, '0, 1'b1);
        check("full_ready", {64'h0, in_ready}, 65'h0);
        check("full_head", {33'h0, pc_commit}, {33'h0, 32'hC00});
        repeat (10) idle(1'b0);

        // async reset with three queued entries
        one(32'hE00, 1'b1);
        one(32'hE10, 1'b1);
        one(32'hE20, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("rst_wen", {64'h0, wen}, 65'h0);
        check("rst_ready", {64'h0, in_ready}, 65'h1);
        check("rst_bcnt", {33'h0, branch_cnt}, 65'h0);
        check("rst_mcnt", {33'h0, mispred_cnt}, 65'h0);
        check("rst_mis", {64'h0, mispredict}, 65'h0);
        exp_q.delete();
        exp_mis = 1'b0; exp_rpc = '0; exp_bcnt = '0; exp_mcnt = '0;
        in_valid = '0; stall = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            v = 2'($urandom);
            for (int l = 0; l < 2; l++) begin
                pc[l]  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                dp[l]  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                tk[l]  = 1'($urandom);
                ptk[l] = ($urandom_range(0, 5) == 0) ? ~tk[l] : tk[l];
                pdp[l] = ($urandom_range(0, 5) == 0) ? dp[l] ^ 32'h40 : dp[l];
            end
            step(v, pc, tk, dp, ptk, pdp, $urandom_range(0, 9) < 4);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) idle(1'b0);
        check("drained", {64'h0, wen}, 65'h0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
